// File: rtl/ssd_attitude_mux.sv
// Two-digit attitude display driver: debounced roll/pitch classification feeding a
// registered, time-multiplexed 7-segment bus. Optional stale/blink logic: SSD_STALE_BLINK_EN.
module ssd_attitude_mux #(
    parameter int DATA_W      = 16,
    parameter int DEADBAND    = 8,
    parameter int STABLE_N    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2,
    parameter int ACTIVE_LOW  = 1,
    parameter int STALE_CYC   = 1000000,
    parameter int BLINK_LOG2  = 5
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Valid,
    input  logic [DATA_W-1:0] i_Roll,
    input  logic [DATA_W-1:0] i_Pitch,
    output logic [6:0]        o_Seg,
    output logic [1:0]        o_Digit,
    output logic              o_Stale
);

    typedef struct packed {
        logic rn;
        logic rz;
        logic pn;
        logic pz;
    } att_class_t;

    typedef enum logic [1:0] {BLANK_L, SHOW_L, BLANK_R, SHOW_R} mux_state_t;

    localparam att_class_t CLASS_LEVEL = '{rn: 1'b0, rz: 1'b1, pn: 1'b0, pz: 1'b1};
    localparam int CNT_W  = $clog2(STABLE_N + 1);
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_N);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_SHOW = SLOT_W'(BLANK_CYC);
    localparam logic signed [DATA_W:0] DB_POS = (DATA_W + 1)'(DEADBAND);
    localparam logic signed [DATA_W:0] DB_NEG = -DB_POS;
    localparam logic POL = (ACTIVE_LOW != 0);

    if (DATA_W < 2 || STABLE_N < 1 || REFRESH_DIV < 4 || BLANK_CYC >= REFRESH_DIV ||
        STALE_CYC < 1 || BLINK_LOG2 < 0) begin : g_bad_params
        $error("ssd_attitude_mux: illegal parameter combination");
    end

    // One extra bit so negating DEADBAND and the most-negative input cannot overflow.
    function automatic logic [1:0] classify(input logic [DATA_W-1:0] x);
        logic signed [DATA_W:0] xe;
        logic                   z;
        xe = $signed({x[DATA_W-1], x});
        z  = (xe >= DB_NEG) && (xe <= DB_POS);
        return {x[DATA_W-1] & ~z, z};
    endfunction

    logic [1:0] roll_nz, pitch_nz;
    att_class_t sample_class;

    assign roll_nz      = classify(i_Roll);
    assign pitch_nz     = classify(i_Pitch);
    assign sample_class = '{rn: roll_nz[1], rz: roll_nz[0], pn: pitch_nz[1], pz: pitch_nz[0]};

    att_class_t        cand_q, cand_d, class_q, class_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        class_d = class_q;
        if (i_Valid) begin
            if (sample_class == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cand_d = sample_class;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == CNT_MAX) class_d = sample_class;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cand_q  <= CLASS_LEVEL;
            class_q <= CLASS_LEVEL;
            cnt_q   <= '0;
        end else begin
            cand_q  <= cand_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

    mux_state_t        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              slot_wrap;

    assign slot_wrap = (slot_q == SLOT_LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= BLANK_L;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        slot_d  = slot_wrap ? '0 : slot_q + 1'b1;
        state_d = state_q;
        case (state_q)
            BLANK_L: if (slot_d >= SLOT_SHOW) state_d = SHOW_L;
            SHOW_L:  if (slot_wrap)           state_d = BLANK_R;
            BLANK_R: if (slot_d >= SLOT_SHOW) state_d = SHOW_R;
            SHOW_R:  if (slot_wrap)           state_d = BLANK_L;
            default:                          state_d = BLANK_L;
        endcase
    end

`ifdef SSD_STALE_BLINK_EN
    localparam int STALE_W = $clog2(STALE_CYC + 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYC);

    logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_d;
    logic [BLINK_LOG2:0] blink_cnt_q, blink_cnt_d;
    logic                stale_q, stale_d;

    always_comb begin
        stale_cnt_d = stale_cnt_q;
        blink_cnt_d = blink_cnt_q;
        if (i_Valid) begin
            stale_cnt_d = '0;
            blink_cnt_d = '0;
        end else begin
            if (stale_cnt_q != STALE_MAX) stale_cnt_d = stale_cnt_q + 1'b1;
            if (stale_q && slot_wrap)     blink_cnt_d = blink_cnt_q + 1'b1;
        end
        stale_d = (stale_cnt_d == STALE_MAX);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            stale_cnt_q <= '0;
            blink_cnt_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            stale_q     <= stale_d;
        end
    end

    assign o_Stale = stale_q;
`else
    assign o_Stale = 1'b0;
`endif

    logic [6:0] lit_l, lit_r, seg_act, seg_d;
    logic [1:0] dig_act, dig_d;

    // Patterns are packed {G,F,E,D,C,B,A}, active-high until the polarity step.
    always_comb begin
        lit_l = {class_q.rz & class_q.pz,
                 ~class_q.rn & class_q.pn & ~class_q.rz,
                 ~class_q.rn & ~class_q.pn & ~class_q.rz,
                 ~class_q.rn & ~class_q.pn & ~class_q.pz,
                 1'b0, 1'b0,
                 ~class_q.rn & class_q.pn & ~class_q.pz};
        lit_r = {class_q.rz & class_q.pz,
                 1'b0, 1'b0,
                 class_q.rn & ~class_q.pn & ~class_q.pz,
                 class_q.rn & ~class_q.pn & ~class_q.rz,
                 class_q.rn & class_q.pn & ~class_q.rz,
                 class_q.rn & class_q.pn & ~class_q.pz};
`ifdef SSD_STALE_BLINK_EN
        if (stale_q) begin
            lit_l = {~blink_cnt_q[BLINK_LOG2], 6'b000000};
            lit_r = lit_l;
        end
`endif
        seg_act = '0;
        dig_act = '0;
        case (state_q)
            SHOW_L: begin
                dig_act = 2'b01;
                seg_act = lit_l;
            end
            SHOW_R: begin
                dig_act = 2'b10;
                seg_act = lit_r;
            end
            default: ;
        endcase
        seg_d = seg_act ^ {7{POL}};
        dig_d = dig_act ^ {2{POL}};
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Seg   <= {7{POL}};
            o_Digit <= {2{POL}};
        end else begin
            o_Seg   <= seg_d;
            o_Digit <= dig_d;
        end
    end

endmodule
